// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button event conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce filter, and press/release/long/repeat classifier.
// Input is already polarity-normalised (1 = pressed).
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = 16,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic clk,
    input  logic nRst,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int DB_W   = cnt_w(DB_CYCLES);
    localparam int HOLD_W = cnt_w(HOLD_CYCLES);
    localparam int REP_W  = cnt_w(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic [DB_W-1:0]   r_db_cnt;
    btn_state_t        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              r_repeat;

    logic              w_accept;
    btn_state_t        w_state_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [REP_W-1:0]  w_rep_nxt;
    logic              w_press_nxt;
    logic              w_release_nxt;
    logic              w_long_nxt;
    logic              w_repeat_nxt;

    // The level flips on this edge; the FSM uses it so pulses align with the new level.
    assign w_accept = (r_sync2 != r_level) && (r_db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_level  <= ~r_level;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rep_cnt  <= w_rep_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
            r_repeat   <= w_repeat_nxt;
        end
    end

    // Release acceptance is checked first so it overrides a coincident long or repeat.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_rep_nxt     = r_rep_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_press_nxt = 1'b1;
                    w_hold_nxt  = '0;
                    w_state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (w_accept) begin
                    w_release_nxt = 1'b1;
                    w_hold_nxt    = '0;
                    w_rep_nxt     = '0;
                    w_state_nxt   = IDLE;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_long_nxt  = 1'b1;
                    w_hold_nxt  = '0;
                    w_rep_nxt   = '0;
                    w_state_nxt = HELD;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            HELD: begin
                if (w_accept) begin
                    w_release_nxt = 1'b1;
                    w_hold_nxt    = '0;
                    w_rep_nxt     = '0;
                    w_state_nxt   = IDLE;
                end else if (r_rep_cnt == REP_LAST) begin
                    w_rep_nxt    = '0;
                    w_repeat_nxt = i_repeat_en;
                end else begin
                    w_rep_nxt = r_rep_cnt + REP_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_hold_nxt  = '0;
                w_rep_nxt   = '0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_events.sv
// Multi-channel push-button conditioner: normalises pin polarity and fans out to
// one independent btn_channel per button.
module button_events
    import btn_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int DB_CYCLES     = 16,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse
);

    logic [N_BTN-1:0] w_pressed;

    assign w_pressed = ACTIVE_LOW ? ~btn_in : btn_in;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk        (clk),
            .nRst       (nRst),
            .i_btn      (w_pressed[g]),
            .i_repeat_en(repeat_en[g]),
            .o_level    (level[g]),
            .o_press    (press_pulse[g]),
            .o_release  (release_pulse[g]),
            .o_long     (long_pulse[g]),
            .o_repeat   (repeat_pulse[g])
        );
    end

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: a timing-rule model checked every cycle plus directed scenarios
// with hand-computed event edges.
module tb_button_events;

    localparam int N    = 2;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic [N-1:0] btn_in = '1;
    logic [N-1:0] repeat_en = '0;
    logic [N-1:0] level, press_pulse, release_pulse, long_pulse, repeat_pulse;

    button_events #(
        .N_BTN(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .nRst(nRst), .btn_in(btn_in), .repeat_en(repeat_en),
        .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    // Model: a level flips once the synchronised input has disagreed with it for DB edges.
    bit           m_s1 [N];
    bit           m_s2 [N];
    bit           m_lvl [N];
    int           m_last_eq [N];
    int           m_tp [N];
    logic [N-1:0] e_level = '0, e_press = '0, e_rel = '0, e_long = '0, e_rep = '0;

    int n_press [N], n_rel [N], n_long [N], n_rep [N];
    int t_press [N], t_rel [N], t_long [N], t_rep_first [N], t_rep_last [N];

    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit d, tog;
        int dt;
        cyc++;
        for (int ch = 0; ch < N; ch++) begin
            if (!nRst) begin
                m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_lvl[ch] = 1'b0;
                m_last_eq[ch] = cyc;
                e_press[ch] = 1'b0; e_rel[ch] = 1'b0; e_long[ch] = 1'b0; e_rep[ch] = 1'b0;
                e_level[ch] = 1'b0;
            end else begin
                d = m_s2[ch];
                if (d == m_lvl[ch]) m_last_eq[ch] = cyc;
                tog = (cyc - m_last_eq[ch]) >= DB;
                e_press[ch] = tog && !m_lvl[ch];
                e_rel[ch]   = tog && m_lvl[ch];
                if (tog) begin
                    m_lvl[ch] = !m_lvl[ch];
                    m_last_eq[ch] = cyc;
                    if (m_lvl[ch]) m_tp[ch] = cyc;
                end
                dt = cyc - m_tp[ch];
                e_long[ch] = !tog && m_lvl[ch] && (dt == HOLD);
                e_rep[ch]  = !tog && m_lvl[ch] && (dt > HOLD) && ((dt - HOLD) % REP == 0) && repeat_en[ch];
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = ~btn_in[ch];
                e_level[ch] = m_lvl[ch];
            end
        end
        #1;
        if (cmp_en) begin
            check_vec("level", level, e_level);
            check_vec("press_pulse", press_pulse, e_press);
            check_vec("release_pulse", release_pulse, e_rel);
            check_vec("long_pulse", long_pulse, e_long);
            check_vec("repeat_pulse", repeat_pulse, e_rep);
        end
        for (int ch = 0; ch < N; ch++) begin
            if (press_pulse[ch] === 1'b1) begin n_press[ch]++; t_press[ch] = cyc; end
            if (release_pulse[ch] === 1'b1) begin n_rel[ch]++; t_rel[ch] = cyc; end
            if (long_pulse[ch] === 1'b1) begin n_long[ch]++; t_long[ch] = cyc; end
            if (repeat_pulse[ch] === 1'b1) begin
                if (n_rep[ch] == 0) t_rep_first[ch] = cyc;
                n_rep[ch]++;
                t_rep_last[ch] = cyc;
            end
        end
    end

    task automatic clear_obs();
        for (int ch = 0; ch < N; ch++) begin
            n_press[ch] = 0; n_rel[ch] = 0; n_long[ch] = 0; n_rep[ch] = 0;
            t_press[ch] = -1; t_rel[ch] = -1; t_long[ch] = -1;
            t_rep_first[ch] = -1; t_rep_last[ch] = -1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn0(input bit pressed);
        btn_in[0] = ~pressed;
    endtask

    int s, k;

    initial begin
        clear_obs();
        tick(3);
        cmp_en = 1'b1;
        nRst = 1'b1;
        check_int("reset_level", int'(level), 0);
        check_int("reset_pulses", int'(press_pulse | release_pulse | long_pulse | repeat_pulse), 0);
        tick(4);

        // Clean press, held 10 samples
        clear_obs();
        s = cyc + 1;
        set_btn0(1'b1);
        tick(10);
        check_int("t1_press_latency", t_press[0] - s, 5);
        check_int("t1_press_count", n_press[0], 1);
        check_int("t1_level", int'(level[0]), 1);
        set_btn0(1'b0);
        tick(12);
        check_int("t1_release_count", n_rel[0], 1);
        check_int("t1_ch1_quiet", n_press[1] + n_rel[1] + n_long[1] + n_rep[1], 0);

        // Bounce: five 3-sample presses, then a stable press
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            set_btn0(1'b1); tick(3);
            set_btn0(1'b0); tick(3);
        end
        check_int("t2_no_press_in_bounce", n_press[0], 0);
        s = cyc + 1;
        set_btn0(1'b1);
        tick(12);
        check_int("t2_press_count", n_press[0], 1);
        check_int("t2_press_latency", t_press[0] - s, 5);
        set_btn0(1'b0);
        tick(12);

        // Hold 60 samples with auto-repeat; the repeat due on the release edge is dropped
        clear_obs();
        repeat_en[0] = 1'b1;
        s = cyc + 1;
        set_btn0(1'b1);
        tick(60);
        set_btn0(1'b0);
        tick(12);
        check_int("t3_long_after_press", t_long[0] - t_press[0], 20);
        check_int("t3_first_repeat", t_rep_first[0] - t_long[0], 8);
        check_int("t3_last_repeat", t_rep_last[0] - t_long[0], 32);
        check_int("t3_repeat_count", n_rep[0], 4);
        check_int("t3_release_edge", t_rel[0] - s, 65);
        check_int("t3_release_count", n_rel[0], 1);

        // Same hold without auto-repeat
        clear_obs();
        repeat_en[0] = 1'b0;
        set_btn0(1'b1);
        tick(60);
        set_btn0(1'b0);
        tick(12);
        check_int("t4_long_count", n_long[0], 1);
        check_int("t4_repeat_count", n_rep[0], 0);
        check_int("t4_release_count", n_rel[0], 1);

        // Release accepted on the very edge the hold time expires
        clear_obs();
        set_btn0(1'b1);
        tick(20);
        set_btn0(1'b0);
        tick(12);
        check_int("t5_long_count", n_long[0], 0);
        check_int("t5_release_count", n_rel[0], 1);
        check_int("t5_release_vs_press", t_rel[0] - t_press[0], 20);

        // Reset while held in HELD
        clear_obs();
        repeat_en[0] = 1'b1;
        set_btn0(1'b1);
        tick(35);
        check_int("t6_long_before_reset", n_long[0], 1);
        nRst = 1'b0;
        k = cyc + 1;
        tick(1);
        check_int("t6_reset_level", int'(level), 0);
        check_int("t6_reset_pulses", int'(press_pulse | release_pulse | long_pulse | repeat_pulse), 0);
        nRst = 1'b1;
        tick(12);
        check_int("t6_repress_latency", t_press[0] - k, 6);
        check_int("t6_press_count", n_press[0], 2);
        check_int("t6_no_release", n_rel[0], 0);
        set_btn0(1'b0);
        tick(12);
        check_int("t6_final_release", n_rel[0], 1);
        check_int("t6_ch1_quiet", n_press[1] + n_rel[1] + n_long[1] + n_rep[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_events.md
# button_events

Multi-channel push-button conditioner that generalises the single-button debounce-plus-falling-edge block. It serves N_BTN independent buttons. Per channel it synchronises, debounces and classifies the input, and emits one-cycle event pulses: press, release, long-press and auto-repeat. It sits between the board button pins and the menu/control FSMs, replacing per-button debounce and edge-detect instances.

## Interface
- N_BTN, 4: number of independent channels.
- DB_CYCLES, 16: consecutive stable samples required to accept a level change; minimum 1.
- HOLD_CYCLES, 1000: cycles after press_pulse at which long_pulse fires; minimum 1.
- REPEAT_CYCLES, 250: auto-repeat period in the HELD state; minimum 1.
- ACTIVE_LOW, 1: 1 means raw 0 is pressed (pull-up buttons); 0 means raw 1 is pressed.
- clk  in  1  clock; all logic on its rising edge.
- nRst  in  1  reset, synchronous, active-low.
- btn_in  in  N_BTN  raw asynchronous button pins.
- repeat_en  in  N_BTN  per-channel auto-repeat enable; sampled every cycle.
- level  out  N_BTN  debounced pressed level; 1 means pressed, independent of ACTIVE_LOW.
- press_pulse  out  N_BTN  one cycle on accepted press.
- release_pulse  out  N_BTN  one cycle on accepted release.
- long_pulse  out  N_BTN  one cycle when a press has lasted HOLD_CYCLES.
- repeat_pulse  out  N_BTN  one cycle every REPEAT_CYCLES while held and repeat_en=1.

## Operation
- Channels are fully independent; no shared state.
- Input path: polarity-normalise to "pressed = 1", then a 2-flop synchroniser (sync1, sync2).
- Debounce:
  - db_cnt increments each cycle sync2 != level; it clears when they are equal.
  - When db_cnt would reach DB_CYCLES, level toggles and db_cnt clears.
  - A glitch shorter than DB_CYCLES samples never toggles level.
- FSM states, per channel:
  - IDLE: level=0. On press accept, assert press_pulse, clear hold_cnt, go to PRESSED.
  - PRESSED: hold_cnt increments each cycle. When it reaches HOLD_CYCLES, assert long_pulse, clear rep_cnt, go to HELD.
  - HELD: rep_cnt increments each cycle. When it reaches REPEAT_CYCLES, clear it; if repeat_en=1, also assert repeat_pulse.
  - Release accept in PRESSED or HELD: assert release_pulse, clear hold_cnt and rep_cnt, go to IDLE.
- Simultaneous events:
  - Release accept in the same cycle hold_cnt reaches HOLD_CYCLES: release wins, no long_pulse.
  - Release accept in the same cycle rep_cnt reaches REPEAT_CYCLES: release wins, no repeat_pulse.
- repeat_en deasserted in HELD: rep_cnt keeps running and pulses are suppressed; the repeat phase is preserved.
- Counter widths: $clog2(param+1) bits each. Counters saturate-free, because they clear at their terminal value.

## Timing
- All outputs are registered. Pulses are exactly one cycle wide.
- Press latency: btn_in first sampled pressed at edge 1 gives level=1 and press_pulse=1 after edge DB_CYCLES+2. Release latency is identical.
- long_pulse: exactly HOLD_CYCLES edges after the press_pulse edge.
- First repeat_pulse: REPEAT_CYCLES edges after the long_pulse edge; then every REPEAT_CYCLES edges.
- Reset, whether from power-up or mid-operation, forces the following on the next edge:
  - sync1/sync2 to the released level;
  - level=0, all pulses 0, all counters 0, FSM to IDLE.
- A button held through reset is reported as a fresh press DB_CYCLES+2 edges after nRst rises. No release_pulse is emitted for the press interrupted by reset.

## Structure
- Package btn_pkg: state typedef btn_state_t {IDLE, PRESSED, HELD}, and a function for counter width.
- Sub-module btn_channel holds the synchroniser, debounce, FSM and counters for one button. It is instanced N_BTN times with a generate loop.
- Top level does only polarity normalisation and bit slicing.

## Test plan
All scenarios use DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, N_BTN=2.
- Clean press on channel 0 at edge 1, held 10 cycles -> press_pulse[0] after edge 6, level[0]=1; channel 1 stays quiet.
- Bounce of 3-cycle pulses repeated 5 times, then a stable press -> exactly one press_pulse; none during bounce.
- Hold 60 cycles with repeat_en=1 -> long_pulse 20 edges after press_pulse; repeat_pulse at +8, +16, +24, ...; then release_pulse on release.
- Same hold with repeat_en=0 -> long_pulse only, no repeat_pulse.
- Release accepted on the exact edge hold_cnt hits 20 -> release_pulse only, no long_pulse.
- nRst pulsed low while in HELD with the button still held -> outputs 0 next edge; press_pulse 6 edges after reset release; no release_pulse.
